// File: rtl/tetris_vga_renderer_if.sv
// Board input and VGA output bundle of the Tetris scan-out engine.
// master = renderer side, slave = board source / VGA sink side.
interface tetris_vga_renderer_if #(
   parameter int unsigned ROWS = 20,
   parameter int unsigned COLS = 10
);
   logic [2*ROWS*COLS-1:0] Blocks;
   logic                   frame_start;
   logic                   VGA_HS;
   logic                   VGA_VS;
   logic [3:0]             VGA_R;
   logic [3:0]             VGA_G;
   logic [3:0]             VGA_B;

   modport master (
      input  Blocks,
      output frame_start, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
   );

   modport slave (
      output Blocks,
      input  frame_start, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
   );
endinterface

// File: rtl/tetris_vga_renderer.sv
// VGA scan-out of a ROWS x COLS Tetris board with a solid border, using a
// per-frame board snapshot and a 2-stage colour/sync pipeline.
module tetris_vga_renderer #(
   parameter int unsigned H_VIS    = 800,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned H_SW     = 128,
   parameter int unsigned H_BP     = 88,
   parameter int unsigned V_VIS    = 600,
   parameter int unsigned V_FP     = 1,
   parameter int unsigned V_SW     = 4,
   parameter int unsigned V_BP     = 23,
   parameter bit          SYNC_POL = 1'b1,
   parameter int unsigned COLS     = 10,
   parameter int unsigned ROWS     = 20,
   parameter int unsigned CELL     = 15,
   parameter int unsigned ORG_X    = 325,
   parameter int unsigned ORG_Y    = 150,
   parameter int unsigned BORDER   = 20
) (
   input logic                   clk_40MHz,
   input logic                   reset,
   tetris_vga_renderer_if.master vga
);

   localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
   localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned PW      = $clog2(CELL + 1);
   localparam int unsigned CW      = $clog2(COLS + 1);
   localparam int unsigned RW      = $clog2(ROWS + 1);
   localparam int unsigned NBITS   = 2 * ROWS * COLS;
   localparam int unsigned IW      = (NBITS > 1) ? $clog2(NBITS) : 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SNAP = VW'(V_VIS);
   localparam logic [PW-1:0] P_LAST = PW'(CELL - 1);

   // One extra bit so window ends equal to the line/frame total still compare correctly.
   localparam logic [HW:0] HS_ON  = (HW+1)'(H_VIS + H_FP);
   localparam logic [HW:0] HS_OFF = (HW+1)'(H_VIS + H_FP + H_SW);
   localparam logic [HW:0] HV     = (HW+1)'(H_VIS);
   localparam logic [HW:0] X0     = (HW+1)'(ORG_X);
   localparam logic [HW:0] X1     = (HW+1)'(ORG_X + COLS*CELL);
   localparam logic [HW:0] AX0    = (HW+1)'(ORG_X - BORDER);
   localparam logic [HW:0] AX1    = (HW+1)'(ORG_X + COLS*CELL + BORDER);
   localparam logic [VW:0] VS_ON  = (VW+1)'(V_VIS + V_FP);
   localparam logic [VW:0] VS_OFF = (VW+1)'(V_VIS + V_FP + V_SW);
   localparam logic [VW:0] VV     = (VW+1)'(V_VIS);
   localparam logic [VW:0] Y0     = (VW+1)'(ORG_Y);
   localparam logic [VW:0] Y1     = (VW+1)'(ORG_Y + ROWS*CELL);
   localparam logic [VW:0] AY0    = (VW+1)'(ORG_Y - BORDER);
   localparam logic [VW:0] AY1    = (VW+1)'(ORG_Y + ROWS*CELL + BORDER);

   if (BORDER > ORG_X || BORDER > ORG_Y ||
       ORG_X + COLS*CELL + BORDER > H_VIS ||
       ORG_Y + ROWS*CELL + BORDER > V_VIS) begin : g_bad_geometry
      $error("tetris_vga_renderer: bordered board does not fit in the visible area");
   end

   logic [HW-1:0]    h_q, h_d;
   logic [VW-1:0]    v_q, v_d;
   logic [PW-1:0]    px_q, px_d, py_q, py_d;
   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [NBITS-1:0] snap_q;
   logic             vis1_q, int1_q, bord1_q, hs1_q, vs1_q;
   logic [1:0]       cell1_q;
   logic [11:0]      rgb_q, rgb_d;
   logic             hs_q, vs_q;

   logic [HW:0]   hx;
   logic [VW:0]   vy;
   logic          h_wrap, in_x, in_y, interior, around, border;
   logic          hs_raw, vs_raw, vis, snap_pt;
   logic [IW-1:0] bit_idx;
   logic [1:0]    cell_sel;

   always_comb begin
      h_wrap = (h_q == H_LAST);
      h_d    = h_wrap ? '0 : h_q + HW'(1);
      v_d    = v_q;
      if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);

      hx       = {1'b0, h_q};
      vy       = {1'b0, v_q};
      hs_raw   = (hx >= HS_ON) && (hx < HS_OFF);
      vs_raw   = (vy >= VS_ON) && (vy < VS_OFF);
      vis      = (hx < HV) && (vy < VV);
      in_x     = (hx >= X0) && (hx < X1);
      in_y     = (vy >= Y0) && (vy < Y1);
      interior = in_x && in_y;
      around   = (hx >= AX0) && (hx < AX1) && (vy >= AY0) && (vy < AY1);
      border   = around && !interior;
      snap_pt  = (h_q == '0) && (v_q == V_SNAP);

      // Cell position tracks the counters one pixel ahead, so it is valid on the cycle it is used.
      px_d  = px_q;
      col_d = col_q;
      if ({1'b0, h_d} == X0) begin
         px_d  = '0;
         col_d = '0;
      end else if (in_x) begin
         if (px_q == P_LAST) begin
            px_d  = '0;
            col_d = col_q + CW'(1);
         end else begin
            px_d = px_q + PW'(1);
         end
      end

      py_d  = py_q;
      row_d = row_q;
      if (h_wrap) begin
         if ({1'b0, v_d} == Y0) begin
            py_d  = '0;
            row_d = '0;
         end else if (in_y) begin
            if (py_q == P_LAST) begin
               py_d  = '0;
               row_d = row_q + RW'(1);
            end else begin
               py_d = py_q + PW'(1);
            end
         end
      end

      bit_idx  = IW'(32'(row_q) * COLS * 2 + 32'(col_q) * 2);
      cell_sel = interior ? snap_q[bit_idx +: 2] : 2'b00;
   end

   always_comb begin
      rgb_d = 12'h000;
      if (vis1_q) begin
         if (int1_q) begin
            case (cell1_q)
               2'b00:   rgb_d = 12'h000;
               2'b01:   rgb_d = 12'hFFF;
               2'b10:   rgb_d = 12'hF00;
               default: rgb_d = 12'h0FF;
            endcase
         end else if (bord1_q) begin
            rgb_d = 12'h0F0;
         end
      end
   end

   always_ff @(posedge clk_40MHz) begin
      if (reset) begin
         h_q     <= '0;
         v_q     <= '0;
         px_q    <= '0;
         py_q    <= '0;
         col_q   <= '0;
         row_q   <= '0;
         snap_q  <= '0;
         vis1_q  <= 1'b0;
         int1_q  <= 1'b0;
         bord1_q <= 1'b0;
         cell1_q <= '0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         rgb_q   <= '0;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         px_q    <= px_d;
         py_q    <= py_d;
         col_q   <= col_d;
         row_q   <= row_d;
         if (snap_pt) snap_q <= vga.Blocks;
         vis1_q  <= vis;
         int1_q  <= interior;
         bord1_q <= border;
         cell1_q <= cell_sel;
         hs1_q   <= hs_raw;
         vs1_q   <= vs_raw;
         rgb_q   <= rgb_d;
         hs_q    <= hs1_q ^ ~SYNC_POL;
         vs_q    <= vs1_q ^ ~SYNC_POL;
      end
   end

   assign vga.frame_start = snap_pt && !reset;
   assign vga.VGA_HS      = hs_q;
   assign vga.VGA_VS      = vs_q;
   assign vga.VGA_R       = rgb_q[11:8];
   assign vga.VGA_G       = rgb_q[7:4];
   assign vga.VGA_B       = rgb_q[3:0];

endmodule
